// File: rtl/alu_instr_encoder.sv
// Packs ALU operation requests into RV32I R-type/I-type words and queues them for a consumer.
// Define ALU_ENC_STATS_EN to add the enc_count/rej_count statistics outputs.
module alu_instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_alu_ctrl,
    input  logic        req_imm_form,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [11:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        err_illegal,
`ifdef ALU_ENC_STATS_EN
    output logic [15:0] enc_count,
    output logic [7:0]  rej_count,
`endif
    input  logic        err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;

    logic          accept, illegal, push, pop;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [6:0]    opcode;
    logic [31:0]   word;

    always_comb begin
        funct3  = 3'b000;
        funct7  = 7'b0000000;
        illegal = 1'b0;
        case (req_alu_ctrl)
            3'b000: funct3 = 3'b000;
            3'b001: begin
                funct7  = 7'b0100000;
                // sub has no immediate form in RV32I
                illegal = req_imm_form;
            end
            3'b010: funct3 = 3'b111;
            3'b011: funct3 = 3'b110;
            3'b101: funct3 = 3'b010;
            default: illegal = 1'b1;
        endcase
        opcode = req_imm_form ? 7'b0010011 : 7'b0110011;
        if (req_imm_form) begin
            word = {req_imm, req_rs1, funct3, req_rd, opcode};
        end else begin
            word = {funct7, req_rs2, req_rs1, funct3, req_rd, opcode};
        end
    end

    assign req_ready   = (count_q != FullCount);
    assign instr_valid = (count_q != '0);
    assign accept      = req_valid && req_ready;
    assign push        = accept && !illegal;
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? mem_q[rptr_q] : 32'h0;
    assign err_illegal = err_q;

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // A new rejection wins over a clear arriving in the same cycle
        if (accept && illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: entries are only visible through a non-zero count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= word;
        end
    end

`ifdef ALU_ENC_STATS_EN
    logic [15:0] enc_q;
    logic [7:0]  rej_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            enc_q <= '0;
            rej_q <= '0;
        end else begin
            if (push && (enc_q != '1)) begin
                enc_q <= enc_q + 16'd1;
            end
            if (accept && illegal && (rej_q != '1)) begin
                rej_q <= rej_q + 8'd1;
            end
        end
    end

    assign enc_count = enc_q;
    assign rej_count = rej_q;
`else
    // This build carries no statistics counters.
`endif

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Self-checking bench for alu_instr_encoder: directed encodings, illegal handling, FIFO full/drain,
// randomized traffic against a queue-based reference model, and mid-stream reset.
module tb_alu_instr_encoder;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_alu_ctrl = 3'd0;
    logic        req_imm_form = 1'b0;
    logic [4:0]  req_rd = 5'd0;
    logic [4:0]  req_rs1 = 5'd0;
    logic [4:0]  req_rs2 = 5'd0;
    logic [11:0] req_imm = 12'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic        err_illegal;
    logic        err_clr = 1'b0;
`ifdef ALU_ENC_STATS_EN
    logic [15:0] enc_count;
    logic [7:0]  rej_count;
`endif

    alu_instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_alu_ctrl (req_alu_ctrl),
        .req_imm_form (req_imm_form),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .err_illegal  (err_illegal),
`ifdef ALU_ENC_STATS_EN
        .enc_count    (enc_count),
        .rej_count    (rej_count),
`endif
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_err = 1'b0;
    int          m_enc = 0;
    int          m_rej = 0;

    function automatic bit ref_illegal(input logic [2:0] c, input logic f);
        return (c == 3'd4) || (c == 3'd6) || (c == 3'd7) || ((c == 3'd1) && f);
    endfunction

    function automatic logic [31:0] ref_encode(input logic [2:0] c, input logic f,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [11:0] imm);
        int unsigned f3, f7, w;
        f3 = 0;
        f7 = 0;
        case (c)
            3'd1: f7 = 32;
            3'd2: f3 = 7;
            3'd3: f3 = 6;
            3'd5: f3 = 2;
            default: f3 = 0;
        endcase
        if (f) begin
            w = int'(imm) * (2 ** 20) + int'(rs1) * (2 ** 15) + f3 * (2 ** 12)
                + int'(rd) * (2 ** 7) + 19;
        end else begin
            w = f7 * (2 ** 25) + int'(rs2) * (2 ** 20) + int'(rs1) * (2 ** 15)
                + f3 * (2 ** 12) + int'(rd) * (2 ** 7) + 51;
        end
        return w;
    endfunction

    // Advance one clock and update the model from the inputs that were presented at the edge.
    task automatic tick();
        bit acc, ill, pp;
        logic [31:0] w;
        acc = req_valid && (mq.size() < DEPTH);
        ill = ref_illegal(req_alu_ctrl, req_imm_form);
        pp  = (mq.size() > 0) && instr_ready;
        w   = ref_encode(req_alu_ctrl, req_imm_form, req_rd, req_rs1, req_rs2, req_imm);
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_err = 1'b0;
            m_enc = 0;
            m_rej = 0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc && !ill) begin
                mq.push_back(w);
                if (m_enc < 65535) m_enc++;
            end
            if (acc && ill) begin
                m_err = 1'b1;
                if (m_rej < 255) m_rej++;
            end else if (err_clr) begin
                m_err = 1'b0;
            end
        end
    endtask

    task automatic set_req(input logic [2:0] c, input logic f, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        req_alu_ctrl = c;
        req_imm_form = f;
        req_rd       = rd;
        req_rs1      = rs1;
        req_rs2      = rs2;
        req_imm      = imm;
    endtask

    task automatic rand_fields();
        req_rd  = 5'($urandom_range(0, 31));
        req_rs1 = 5'($urandom_range(0, 31));
        req_rs2 = 5'($urandom_range(0, 31));
        req_imm = 12'($urandom_range(0, 4095));
        req_imm_form = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_legal();
        logic [2:0] legal [5];
        legal = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
        rand_fields();
        req_alu_ctrl = legal[$urandom_range(0, 4)];
        if (req_alu_ctrl == 3'd1) req_imm_form = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_illegal); end
`ifdef ALU_ENC_STATS_EN
        n_checks++; if (enc_count !== 16'd0 || rej_count !== 8'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", enc_count, rej_count); end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [2:0]  ctl [4];
        logic        frm [4];
        logic [4:0]  rd [4];
        logic [4:0]  rs1 [4];
        logic [4:0]  rs2 [4];
        logic [11:0] imm [4];
        logic [31:0] expw [4];
        ctl  = '{3'd0, 3'd1, 3'd5, 3'd0};
        frm  = '{1'b0, 1'b0, 1'b0, 1'b1};
        rd   = '{5'd3, 5'd5, 5'd10, 5'd1};
        rs1  = '{5'd1, 5'd6, 5'd11, 5'd0};
        rs2  = '{5'd2, 5'd7, 5'd12, 5'd0};
        imm  = '{12'd0, 12'd0, 12'd0, 12'hFFF};
        expw = '{32'h002081B3, 32'h407302B3, 32'h00C5A533, 32'hFFF00093};
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(ctl[i], frm[i], rd[i], rs1[i], rs2[i], imm[i]);
            req_valid = 1'b1;
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pre_valid: got %b want 0", i, instr_valid); end
            tick();
            req_valid = 1'b0;
            n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %b want 1", i, instr_valid); end
            n_checks++; if (instr !== expw[i]) begin n_fail++; $display("FAIL dir%0d_instr: got %h want %h", i, instr, expw[i]); end
            tick();
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_popped: got %b want 0", i, instr_valid); end
            n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL dir%0d_zero: got %h want 0", i, instr); end
        end
    endtask

    task automatic test_illegal();
        instr_ready = 1'b1;
        set_req(3'd1, 1'b1, 5'd4, 5'd4, 5'd4, 12'h123);
        req_valid = 1'b1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %b want 1", req_ready); end
        tick();
        set_req(3'd7, 1'b0, 5'd1, 5'd2, 5'd3, 12'h0);
        n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_err_set: got %b want 1", err_illegal); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ill_nowrite1: got %b want 0", instr_valid); end
        tick();
        req_valid = 1'b0;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ill_nowrite2: got %b want 0", instr_valid); end
`ifdef ALU_ENC_STATS_EN
        n_checks++; if (rej_count !== 8'd2) begin n_fail++; $display("FAIL ill_rej_count: got %0d want 2", rej_count); end
        n_checks++; if (enc_count !== 16'd4) begin n_fail++; $display("FAIL ill_enc_count: got %0d want 4", enc_count); end
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_err_hold%0d: got %b want 1", i, err_illegal); end
        end
        // Set and clear together: set wins
        set_req(3'd6, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0);
        req_valid = 1'b1;
        err_clr = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_set_prio: got %b want 1", err_illegal); end
        tick();
        err_clr = 1'b0;
        n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_clr: got %b want 0", err_illegal); end
    endtask

    task automatic test_full();
        instr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_legal();
            req_valid = 1'b1;
            tick();
            n_checks++; if (req_ready !== (i < DEPTH - 1)) begin n_fail++; $display("FAIL full_ready%0d: got %b want %b", i, req_ready, (i < DEPTH - 1)); end
        end
        rand_legal();
        tick();
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_ready: got %b want 0", req_ready); end
        n_checks++; if (instr !== mq[0]) begin n_fail++; $display("FAIL full_hold_head: got %h want %h", instr, mq[0]); end
        instr_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready%0d: got %b want 1", i, req_ready); end
            n_checks++; if (instr_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL drain_valid%0d: got %b want %b", i, instr_valid, (mq.size() > 0)); end
            if (mq.size() > 0) begin
                n_checks++; if (instr !== mq[0]) begin n_fail++; $display("FAIL drain_order%0d: got %h want %h", i, instr, mq[0]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        instr_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_legal();
            tick();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_legal();
            tick();
            n_checks++; if (instr !== mq[0]) begin n_fail++; $display("FAIL b2b_head%0d: got %h want %h", i, instr, mq[0]); end
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready); end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (instr_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL b2b_drain%0d: got %b want %b", i, instr_valid, (mq.size() > 0)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_fields();
            req_alu_ctrl = 3'($urandom_range(0, 7));
            req_valid   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            err_clr     = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++; if (instr_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, instr_valid, (mq.size() > 0)); end
            n_checks++; if (instr !== ((mq.size() > 0) ? mq[0] : 32'h0)) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h want %h", i, instr, (mq.size() > 0) ? mq[0] : 32'h0); end
            n_checks++; if (req_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", i, req_ready, (mq.size() < DEPTH)); end
            n_checks++; if (err_illegal !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", i, err_illegal, m_err); end
        end
        req_valid = 1'b0;
        err_clr = 1'b0;
`ifdef ALU_ENC_STATS_EN
        n_checks++; if (enc_count !== 16'(m_enc)) begin n_fail++; $display("FAIL rnd_enc_count: got %0d want %0d", enc_count, m_enc); end
        n_checks++; if (rej_count !== 8'(m_rej)) begin n_fail++; $display("FAIL rnd_rej_count: got %0d want %0d", rej_count, m_rej); end
`endif
    endtask

    task automatic test_reset_midstream();
        instr_ready = 1'b1;
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_legal();
            tick();
        end
        set_req(3'd4, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0);
        tick();
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got %b want 1", instr_valid); end
        n_checks++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL mid_err_before: got %b want 1", err_illegal); end
        rand_legal();
        reset = 1'b1;
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL mid_instr: got %h want 0", instr); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", req_ready); end
        n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b want 0", err_illegal); end
`ifdef ALU_ENC_STATS_EN
        n_checks++; if (enc_count !== 16'd0 || rej_count !== 8'd0) begin n_fail++; $display("FAIL mid_stats: got %0d/%0d want 0/0", enc_count, rej_count); end
`endif
        reset = 1'b0;
        req_valid = 1'b0;
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_handshake: got %b want 0", instr_valid); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_instr_encoder.md
# alu_instr_encoder

Inverse of the ALU control decode path. It accepts ALU operation requests (3-bit ALU control code, register indices, optional 12-bit immediate) over a valid/ready handshake. It assembles the matching 32-bit RV32I R-type or I-type instruction word and buffers it in a small FIFO for a downstream consumer (self-test sequencer / instruction memory loader). Codes with no legal encoding are rejected and flagged.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_alu_ctrl  in  3  ALU control code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- req_imm_form  in  1  1 = I-type (opcode 0010011), 0 = R-type (opcode 0110011).
- req_rd, req_rs1, req_rs2  in  5 each  register indices; rs2 ignored when imm_form=1.
- req_imm  in  12  immediate; ignored when imm_form=0.
- instr_valid  out  1  FIFO head holds a word.
- instr_ready  in  1  consumer takes head.
- instr  out  32  encoded word at FIFO head.
- err_illegal  out  1  sticky: an illegal request was rejected.
- err_clr  in  1  clears err_illegal.

## Operation
- Accept on req_valid && req_ready; req_ready = !full (registered count; no path from instr_ready).
- Encoding is fixed: {funct7, rs2, rs1, funct3, rd, opcode} for R-type and {imm[11:0], rs1, funct3, rd, opcode} for I-type.
  - add: funct3 000, funct7 0000000. sub: funct3 000, funct7 0100000.
  - slt: 010. or: 110. and: 111.
- Illegal: alu_ctrl ∈ {100, 110, 111}, or sub with imm_form=1.
  - Illegal requests are still accepted (handshake completes) but not written.
  - err_illegal sets the next cycle.
- err_illegal: set has priority over err_clr in the same cycle; otherwise cleared by err_clr or reset.
- FIFO: write/read pointers of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when empty: ignored. Push when full: cannot occur (ready low).
- instr driven from the head entry; undefined content is never exposed when instr_valid=0 (drive 0).

## Timing
- Reset values: req_ready=1, instr_valid=0, instr=0, err_illegal=0, pointers/count=0, stats counters 0.
- Latency: request accepted in cycle N → instr_valid=1 in N+1 (empty FIFO). No combinational req→instr path.
- Throughput: one request per cycle while not full; one pop per cycle.
- Full: req_ready falls in the cycle after the DEPTH-th push. It rises the cycle after a pop frees a slot.
- Reset mid-stream: all buffered words are discarded, outputs return to reset values the next cycle, and no partial handshake completes.
- instr/instr_valid hold stable while instr_valid && !instr_ready.

## Configuration
- ALU_ENC_STATS_EN defined:
  - Adds output enc_count (16) = legal words pushed.
  - Adds output rej_count (8) = illegal requests rejected.
  - Both saturate at all-ones and clear on reset only.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- add rd=3 rs1=1 rs2=2 R-type, instr_ready=1 → instr=0x002081B3, instr_valid high exactly one cycle after accept.
- sub rd=5 rs1=6 rs2=7 → 0x407302B3; slt rd=10 rs1=11 rs2=12 → 0x00C5A533.
- I-type add rd=1 rs1=0 imm=0xFFF → 0xFFF00093.
- I-type sub, then alu_ctrl=111:
  - both accepted, no FIFO write;
  - err_illegal=1 from the next cycle and held until err_clr;
  - with ALU_ENC_STATS_EN, rej_count=2.
- instr_ready=0, push DEPTH legal words → req_ready=0 after 4th; assert instr_ready → words pop in order, req_ready=1 the cycle after the first pop; simultaneous push+pop keeps count.
- Assert reset with 3 words buffered → next cycle instr_valid=0, instr=0, req_ready=1, err_illegal=0.
